// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU with valid/ready handshakes, status flags
// and an iterative shift-add multiplier. One operation in flight at a time.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Opcode,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Zero,
    output logic             Neg,
    output logic             Carry,
    output logic             Ovf
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;

    logic               accept;
    logic               mul_last;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_c;
    logic               alu_v;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;

    assign accept   = In_valid && (state == IDLE);
    assign mul_last = (state == EXEC) && (cnt == SHW'(WIDTH - 1));

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept in IDLE, step multiplier in EXEC, hold in DONE until consumed
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (In_valid) begin
                    next_state = (Opcode == OP_MUL) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (mul_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (Out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Single-cycle result and flags for the non-multiply opcodes
    always_comb begin
        add_w = {1'b0, A} + {1'b0, B};
        sub_w = {1'b0, A} - {1'b0, B};
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (Opcode)
            OP_ADD: begin
                alu_y = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_y = A & B;
            OP_OR:  alu_y = A | B;
            OP_XOR: alu_y = A ^ B;
            OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SHL: alu_y = A << B[SHW-1:0];
            default: alu_y = '0;
        endcase
    end

    // One shift-add step: conditionally add multiplicand to the high half, shift right
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{acc[0]}}};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Datapath: register simple results on accept, run the multiplier in EXEC
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            Y     <= '0;
            Zero  <= 1'b0;
            Neg   <= 1'b0;
            Carry <= 1'b0;
            Ovf   <= 1'b0;
        end else if (accept) begin
            if (Opcode == OP_MUL) begin
                mcand <= A;
                acc   <= {{WIDTH{1'b0}}, B};
                cnt   <= '0;
            end else begin
                Y     <= alu_y;
                Zero  <= (alu_y == '0);
                Neg   <= alu_y[WIDTH-1];
                Carry <= alu_c;
                Ovf   <= alu_v;
            end
        end else if (state == EXEC) begin
            acc <= acc_next;
            cnt <= cnt + SHW'(1);
            if (mul_last) begin
                Y     <= acc_next[WIDTH-1:0];
                Zero  <= (acc_next[WIDTH-1:0] == '0);
                Neg   <= acc_next[WIDTH-1];
                Carry <= |acc_next[2*WIDTH-1:WIDTH];
                Ovf   <= 1'b0;
            end
        end
    end

    // Handshake outputs registered from the next state; both low while in reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            In_ready  <= 1'b0;
            Out_valid <= 1'b0;
        end else begin
            In_ready  <= (next_state == IDLE);
            Out_valid <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32).
module tb_seq_alu;

    localparam int unsigned WIDTH = 32;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [2:0]       Opcode = 3'd0;
    logic             In_valid = 1'b0;
    logic             In_ready;
    logic [WIDTH-1:0] Y;
    logic             Out_valid;
    logic             Out_ready = 1'b0;
    logic             Zero;
    logic             Neg;
    logic             Carry;
    logic             Ovf;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .A         (A),
        .B         (B),
        .Opcode    (Opcode),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Y         (Y),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Zero      (Zero),
        .Neg       (Neg),
        .Carry     (Carry),
        .Ovf       (Ovf)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op);
        chk({tag, "_rdy_before"}, In_ready, 1'b1);
        A        = a;
        B        = b;
        Opcode   = op;
        In_valid = 1'b1;
        step();
        In_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] ey, input logic [3:0] ef);
        chk({tag, "_valid"}, Out_valid, 1'b1);
        chk({tag, "_y"}, Y, ey);
        chk({tag, "_zncv"}, {Zero, Neg, Carry, Ovf}, ef);
    endtask

    task automatic consume(input string tag);
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
        chk({tag, "_idle"}, {In_ready, Out_valid}, 2'b10);
    endtask

    // Simple op: result visible right after the accepting edge
    task automatic do_simple(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [2:0] op, input logic [WIDTH-1:0] ey, input logic [3:0] ef);
        issue(tag, a, b, op);
        chk({tag, "_rdy_busy"}, In_ready, 1'b0);
        check_result(tag, ey, ef);
        consume(tag);
    endtask

    // Multiply: Out_valid expected 32 edges after the accepting edge, In_ready low throughout
    task automatic do_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ey, input logic [3:0] ef);
        int n;
        logic rdy_seen;
        issue(tag, a, b, OP_MUL);
        n = 0;
        rdy_seen = In_ready;
        while (!Out_valid && n < 40) begin
            step();
            n++;
            rdy_seen = rdy_seen | In_ready;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_rdy_low"}, rdy_seen, 1'b0);
        check_result(tag, ey, ef);
        consume(tag);
    endtask

    initial begin
        logic stable;

        // Reset state
        #3;
        chk("rst_y", Y, 32'h0);
        chk("rst_flags", {Zero, Neg, Carry, Ovf}, 4'b0000);
        chk("rst_hs", {In_ready, Out_valid}, 2'b00);
        step();
        step();
        chk("rst_hold_rdy", In_ready, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        chk("post_rst_rdy", In_ready, 1'b1);

        // Simple ops on the reference operands
        do_simple("add", 32'h0FFAC078, 32'h0F42FAB2, OP_ADD, 32'h1F3DBB2A, 4'b0000);
        do_simple("sub", 32'h0FFAC078, 32'h0F42FAB2, OP_SUB, 32'h00B7C5C6, 4'b0000);
        do_simple("and", 32'h0FFAC078, 32'h0F42FAB2, OP_AND, 32'h0F42C030, 4'b0000);
        do_simple("or",  32'h0FFAC078, 32'h0F42FAB2, OP_OR,  32'h0FFAFAFA, 4'b0000);
        do_simple("xor", 32'h0FFAC078, 32'h0F42FAB2, OP_XOR, 32'h00B83ACA, 4'b0000);

        // Flag corner cases ({Zero,Neg,Carry,Ovf})
        do_simple("sub_borrow", 32'h1, 32'h2, OP_SUB, 32'hFFFFFFFF, 4'b0110);
        do_simple("add_ovf", 32'h7FFFFFFF, 32'h1, OP_ADD, 32'h80000000, 4'b0101);
        do_simple("add_wrap", 32'hFFFFFFFF, 32'h1, OP_ADD, 32'h00000000, 4'b1010);
        do_simple("sub_ovf", 32'h80000000, 32'h1, OP_SUB, 32'h7FFFFFFF, 4'b0001);

        // SLT / SHL
        do_simple("slt_true", 32'hFFFFFFFF, 32'h1, OP_SLT, 32'h1, 4'b0000);
        do_simple("slt_false", 32'h1, 32'hFFFFFFFF, OP_SLT, 32'h0, 4'b1000);
        do_simple("shl", 32'h1, 32'h24, OP_SHL, 32'h10, 4'b0000);

        // Multiply
        do_mul("mul_3x5", 32'd3, 32'd5, 32'd15, 4'b0000);
        do_mul("mul_hi", 32'h10000, 32'h10000, 32'h0, 4'b1010);
        do_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0010);
        do_mul("mul_neg", 32'h12345678, 32'h9, 32'hA3D70A38, 4'b0100);

        // Backpressure: hold result while Out_ready is low, ignore new requests
        issue("bp", 32'd2, 32'd3, OP_ADD);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            In_valid = i[0];
            A        = $urandom;
            Opcode   = OP_SUB;
            step();
            if (!(Y == 32'd5 && Out_valid && !In_ready && {Zero, Neg, Carry, Ovf} == 4'b0000))
                stable = 1'b0;
        end
        In_valid = 1'b0;
        chk("bp_stable", stable, 1'b1);
        Out_ready = 1'b1;
        step();
        Out_ready = 1'b0;
        chk("bp_release", {In_ready, Out_valid}, 2'b10);
        chk("bp_y_kept", Y, 32'd5);

        // Asynchronous reset in the middle of a multiply
        issue("rst_mul", 32'd3, 32'd5, OP_MUL);
        repeat (5) step();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("amid_y", Y, 32'h0);
        chk("amid_flags", {Zero, Neg, Carry, Ovf}, 4'b0000);
        chk("amid_hs", {In_ready, Out_valid}, 2'b00);
        step();
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        chk("amid_rdy", In_ready, 1'b1);
        do_simple("after_rst", 32'd2, 32'd2, OP_ADD, 32'd4, 4'b0000);
        repeat (40) step();
        chk("no_stale_mul", {In_ready, Out_valid}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational `simpleALU`: same A/B/Opcode/Y operand style, generalised to WIDTH bits.
- Adds valid/ready handshakes on input and output, status flags, and an iterative shift-add multiply.
- Sits between an operand-issue stage and a result consumer.
- One operation in flight at a time; the FSM sequences accept, execute and hold-until-consumed.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 4. Derived localparam SHW = $clog2(WIDTH), the shift-amount width.

Ports:
- Clk  input  1  clock; all state updates on the rising edge
- Rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Opcode  input  3  operation select
- In_valid  input  1  A/B/Opcode valid
- In_ready  output  1  block can accept an operation
- Y  output  WIDTH  result
- Out_valid  output  1  Y and flags valid
- Out_ready  input  1  consumer takes the result
- Zero  output  1  Y == 0
- Neg  output  1  Y[WIDTH-1]
- Carry  output  1  carry/borrow/multiply overflow
- Ovf  output  1  signed overflow

Behaviour:
- Reset (asynchronous, Rst_n=0):
  - State goes to IDLE.
  - Y=0, Zero=0, Neg=0, Carry=0, Ovf=0, Out_valid=0.
  - In_ready is 0 while Rst_n=0 and 1 in IDLE after release.
  - Reset mid-EXEC or mid-DONE aborts the operation; the partial result is discarded.
- FSM states: IDLE, EXEC, DONE.
  - In_ready = (state==IDLE). Out_valid = (state==DONE).
  - IDLE: on In_valid & In_ready, latch A, B and Opcode.
    - Opcode != 7: compute, register Y and flags, go to DONE. Out_valid rises the cycle after accept.
    - Opcode == 7: load multiplier registers, go to EXEC.
  - EXEC: one shift-add step per cycle, WIDTH cycles total, using a 2*WIDTH-bit accumulator. After the last step, register the result and go to DONE. Out_valid rises WIDTH+1 cycles after accept.
  - DONE: Y and flags held stable. On Out_ready go to IDLE. Out_ready is ignored in other states.
  - In_valid is ignored while not in IDLE; the source must hold its operands.
  - Throughput: at most one operation per 2 cycles (simple ops).
- Opcodes (Y is WIDTH bits; excess bits truncated):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND: A&B
  - 3 OR: A|B
  - 4 XOR: A^B
  - 5 SLT: Y = 1 if $signed(A) < $signed(B), else 0
  - 6 SHL: A << B[SHW-1:0]; the upper bits of B are ignored
  - 7 MUL: unsigned; Y = low WIDTH bits of A*B
- Flags, registered together with Y:
  - Zero = (Y==0); Neg = Y[MSB]; both apply to all ops.
  - Carry:
    - ADD: carry-out.
    - SUB: borrow, i.e. 1 when A < B unsigned.
    - MUL: 1 when the high WIDTH bits of the product are nonzero.
    - All other ops: 0.
  - Ovf:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operands have different signs and the result sign differs from A.
    - All other ops: 0.

Test Plan:
- Simple ops, WIDTH=32, A=32'h0FFAC078, B=32'h0F42FAB2:
  - ADD -> Y=32'h1F3DBB2A, Zero/Neg/Carry/Ovf all 0.
  - SUB -> Y=32'h00B7C5C6, all flags 0.
  - AND/OR/XOR match the bitwise reference.
  - Out_valid is 1 exactly one cycle after accept.
- Flag cases:
  - SUB 1-2 -> Y=32'hFFFFFFFF, Neg=1, Carry=1, Ovf=0.
  - ADD 32'h7FFFFFFF+1 -> Y=32'h80000000, Neg=1, Ovf=1, Carry=0.
  - ADD 32'hFFFFFFFF+1 -> Y=0, Zero=1, Carry=1.
- SLT/SHL:
  - SLT A=32'hFFFFFFFF, B=1 -> Y=1.
  - SHL A=1, B=32'h24 -> Y=32'h10 (shift amount 4).
- MUL:
  - 3*5 -> Y=15, Carry=0; Out_valid rises exactly 33 cycles after accept; In_ready stays 0 throughout.
  - 32'h10000*32'h10000 -> Y=0, Zero=1, Carry=1.
- Backpressure: hold Out_ready=0 for 10 cycles in DONE and toggle In_valid/A -> Y and flags stay stable, In_ready=0, no new accept; raise Out_ready -> IDLE the next cycle.
- Reset: assert Rst_n=0 mid-EXEC, asynchronously between clock edges:
  - All outputs go to reset values immediately.
  - After release, In_ready=1, and a fresh ADD 2+2 returns Y=4.
